// File: rtl/product_accum.sv
// Frame accumulator for signed 16-bit products: sums beats into a saturating
// ACC_W-bit register and offers one result per frame on a valid/ready port.
module product_accum #(
    parameter int ACC_W     = 24,
    parameter int MAX_BEATS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      product,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_ovf,
    output logic [7:0]       out_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [7:0]       MAX_CNT = 8'(MAX_BEATS);

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [7:0]       count, count_nxt;
    logic             ovf, ovf_nxt;

    logic [ACC_W:0]   prod_ext;
    logic [ACC_W:0]   sum;
    logic             sum_ovf;
    logic             beat;

    // One guard bit above the accumulator exposes signed overflow as a
    // disagreement between the top two bits of the sum.
    assign prod_ext = {{(ACC_W+1-16){product[15]}}, product};
    assign sum      = {acc[ACC_W-1], acc} + prod_ext;
    assign sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];

    assign in_ready = (state != HOLD);
    assign beat     = in_valid && in_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt = state;
        acc_nxt   = acc;
        count_nxt = count;
        ovf_nxt   = ovf;
        case (state)
            IDLE: begin
                if (beat) begin
                    acc_nxt   = prod_ext[ACC_W-1:0];
                    count_nxt = 8'd1;
                    ovf_nxt   = 1'b0;
                    state_nxt = (in_last || MAX_CNT == 8'd1) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    if (sum_ovf) begin
                        acc_nxt = sum[ACC_W] ? SAT_MIN : SAT_MAX;
                        ovf_nxt = 1'b1;
                    end else begin
                        acc_nxt = sum[ACC_W-1:0];
                    end
                    count_nxt = count + 8'd1;
                    if (in_last || count_nxt == MAX_CNT) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                    count_nxt = 8'd0;
                    ovf_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state <= IDLE;
            acc   <= '0;
            count <= 8'd0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            count <= count_nxt;
            ovf   <= ovf_nxt;
        end
    end

    // Result fields read as zero whenever no result is being offered.
    assign out_valid = (state == HOLD);
    assign acc_out   = out_valid ? acc   : '0;
    assign out_ovf   = out_valid ? ovf   : 1'b0;
    assign out_count = out_valid ? count : 8'd0;

endmodule

// File: tb/tb_product_accum.sv
// Self-checking bench for product_accum: two configurations driven in turn,
// checked every cycle against a frame-level saturating-sum reference model.
module tb_product_accum;

    localparam int ACC_A = 24;
    localparam int MAXB_A = 8;
    localparam int ACC_B = 17;
    localparam int MAXB_B = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] product = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic        sel = 1'b0;

    logic             in_ready_a, out_valid_a, out_ovf_a;
    logic [ACC_A-1:0] acc_a;
    logic [7:0]       cnt_a;
    logic             in_ready_b, out_valid_b, out_ovf_b;
    logic [ACC_B-1:0] acc_b;
    logic [7:0]       cnt_b;

    logic   in_ready_m, out_valid_m, out_ovf_m;
    longint acc_m;
    logic [7:0] cnt_m;

    int checks = 0;
    int failures = 0;

    int  m_frame[$];
    bit  m_hold = 1'b0;
    bit  accepted = 1'b0;

    always #5 clk = ~clk;

    product_accum #(.ACC_W(ACC_A), .MAX_BEATS(MAXB_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid && !sel), .in_ready(in_ready_a),
        .product(product), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready && !sel),
        .acc_out(acc_a), .out_ovf(out_ovf_a), .out_count(cnt_a)
    );

    product_accum #(.ACC_W(ACC_B), .MAX_BEATS(MAXB_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid && sel), .in_ready(in_ready_b),
        .product(product), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready && sel),
        .acc_out(acc_b), .out_ovf(out_ovf_b), .out_count(cnt_b)
    );

    assign in_ready_m  = sel ? in_ready_b  : in_ready_a;
    assign out_valid_m = sel ? out_valid_b : out_valid_a;
    assign out_ovf_m   = sel ? out_ovf_b   : out_ovf_a;
    assign cnt_m       = sel ? cnt_b       : cnt_a;
    assign acc_m       = sel ? longint'($signed(acc_b)) : longint'($signed(acc_a));

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Saturating running sum of the frame, clamped after every beat.
    task automatic frame_eval(output longint acc, output bit ovf);
        int     accw = sel ? ACC_B : ACC_A;
        longint mx = (longint'(1) <<< (accw - 1)) - 1;
        longint mn = -(longint'(1) <<< (accw - 1));
        acc = 0;
        ovf = 1'b0;
        foreach (m_frame[i]) begin
            acc += m_frame[i];
            if (acc > mx) begin acc = mx; ovf = 1'b1; end
            if (acc < mn) begin acc = mn; ovf = 1'b1; end
        end
    endtask

    // One clock: update the model from the inputs seen at the edge, then
    // compare every output at the following falling edge.
    task automatic tick();
        int     maxb = sel ? MAXB_B : MAXB_A;
        longint e_acc;
        bit     e_ovf;
        @(posedge clk);
        accepted = 1'b0;
        if (!rst_n || clear) begin
            m_frame.delete();
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_frame.delete();
                m_hold = 1'b0;
            end
        end else if (in_valid) begin
            accepted = 1'b1;
            m_frame.push_back(int'($signed(product)));
            if (in_last || m_frame.size() == maxb) m_hold = 1'b1;
        end
        @(negedge clk);
        frame_eval(e_acc, e_ovf);
        check("in_ready",  longint'(in_ready_m),  longint'(!m_hold));
        check("out_valid", longint'(out_valid_m), longint'(m_hold));
        check("acc_out",   acc_m,                 m_hold ? e_acc : 0);
        check("out_ovf",   longint'(out_ovf_m),   m_hold ? longint'(e_ovf) : 0);
        check("out_count", longint'(cnt_m),       m_hold ? longint'(m_frame.size()) : 0);
    endtask

    task automatic send(input logic signed [15:0] p, input logic last);
        int budget = 20;
        in_valid = 1'b1;
        product  = p;
        in_last  = last;
        do begin
            tick();
            budget--;
        end while (!accepted && budget > 0);
        check("send_accepted", longint'(accepted), 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset held for two cycles while a beat is offered: nothing accepted.
        in_valid = 1'b1;
        product  = 16'd55;
        tick();
        tick();
        check("reset_no_accept", longint'(accepted), 0);
        check("reset_in_ready", longint'(in_ready_m), 1);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // Basic three-beat frame.
        out_ready = 1'b1;
        send(16'sd100, 1'b0);
        send(-16'sd30, 1'b0);
        send(16'sd7, 1'b1);
        check("s1_acc", acc_m, 77);
        check("s1_cnt", longint'(cnt_m), 3);
        check("s1_ovf", longint'(out_ovf_m), 0);
        tick();
        check("s1_released", longint'(out_valid_m), 0);

        // MAX_BEATS closes the frame; the remaining beats stall.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        product   = 16'h7FFF;
        for (int i = 0; i < 8; i++) tick();
        check("s2_acc", acc_m, 262136);
        check("s2_cnt", longint'(cnt_m), 8);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s2_stall", longint'(accepted), 0);
        end
        out_ready = 1'b1;
        tick();
        check("s2_handoff_no_accept", longint'(accepted), 0);
        out_ready = 1'b0;
        tick();
        in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("s2_tail_cnt", longint'(cnt_m), 2);
        check("s2_tail_acc", acc_m, 65534);

        // Result held for five cycles, then taken.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send(-16'sd1234, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s4_hold_in_ready", longint'(in_ready_m), 0);
            check("s4_hold_acc", acc_m, -1234);
        end
        out_ready = 1'b1;
        tick();
        check("s4_idle_in_ready", longint'(in_ready_m), 1);

        // Clear mid-frame discards the partial sum and the beat offered with it.
        send(16'sd10, 1'b0);
        send(16'sd20, 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        product  = 16'd99;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        send(-16'sd5, 1'b1);
        check("s5_acc", acc_m, -5);
        check("s5_cnt", longint'(cnt_m), 1);

        // Reset while holding a result.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("s6_out_valid", longint'(out_valid_m), 0);
        check("s6_in_ready", longint'(in_ready_m), 1);
        check("s6_acc", acc_m, 0);

        // Narrow configuration: saturation both ways and the MAX_BEATS bound.
        sel = 1'b1;
        do_reset();
        out_ready = 1'b0;
        send(16'sh7FFF, 1'b0);
        send(16'sh7FFF, 1'b0);
        send(16'sh7FFF, 1'b1);
        check("s3_pos_acc", acc_m, 65535);
        check("s3_pos_ovf", longint'(out_ovf_m), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send(16'sh8000, 1'b0);
        send(16'sh8000, 1'b0);
        send(16'sh8000, 1'b1);
        check("s3_neg_acc", acc_m, -65536);
        check("s3_neg_ovf", longint'(out_ovf_m), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(16'(i), 1'b0);
        check("maxb_cnt", longint'(cnt_m), 4);
        check("maxb_acc", acc_m, 10);
        out_ready = 1'b1;
        tick();

        // Randomised traffic on both configurations.
        for (int k = 0; k < 2; k++) begin
            sel = (k == 1);
            do_reset();
            for (int i = 0; i < 400; i++) begin
                in_valid  = ($urandom % 4) != 0;
                product   = ($urandom % 4 == 0) ? (($urandom % 2) ? 16'h7FFF : 16'h8000)
                                                : 16'($urandom);
                in_last   = ($urandom % 4) == 0;
                out_ready = ($urandom % 3) != 0;
                clear     = ($urandom % 50) == 0;
                rst_n     = ($urandom % 80) != 0;
                tick();
            end
            clear = 1'b0;
            rst_n = 1'b1;
            in_valid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
